cell_tx_queue: RTL

CELL_TX_QUEUE -- requirements
Module: cell_tx_queue

---
 rtl/cell_pkg.sv | 22 ++
 rtl/cell_tx_queue_if.sv | 45 ++++
 rtl/cell_fifo.sv | 68 ++++++
 rtl/cell_tx_queue.sv | 115 +++++++++++
 4 files changed

// File: rtl/cell_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cell_pkg : shared ATM cell width/type for tx queue and serializer     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package cell_pkg;

  localparam int CELL_W = 53;

  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } txq_state_e;

  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cell_tx_queue_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cell_tx_queue_if : producer/serializer-side bus of cell_tx_queue      |
// | Optional drop_count signal when CELL_TXQ_DROP_CNT_EN is defined.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface cell_tx_queue_if #(
  parameter int DEPTH = 4
) ();
  import cell_pkg::*;

  localparam int OCC_W = occ_width(DEPTH);

  cell_t            cell_in;
  logic             valid_in;
  logic             in_ready;
  logic             tx_en;
  cell_t            cell_out;
  logic             valid_out;
  logic [OCC_W-1:0] occupancy;
  logic             overflow;
`ifdef CELL_TXQ_DROP_CNT_EN
  logic [15:0]      drop_count;

  modport slave (
    input  cell_in, valid_in, tx_en,
    output in_ready, cell_out, valid_out, occupancy, overflow, drop_count
  );
  modport master (
    output cell_in, valid_in, tx_en,
    input  in_ready, cell_out, valid_out, occupancy, overflow, drop_count
  );
`else
  modport slave (
    input  cell_in, valid_in, tx_en,
    output in_ready, cell_out, valid_out, occupancy, overflow
  );
  modport master (
    output cell_in, valid_in, tx_en,
    input  in_ready, cell_out, valid_out, occupancy, overflow
  );
`endif

endinterface
`default_nettype wire

// File: rtl/cell_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cell_fifo : power-of-two cell FIFO with wrapping pointers + occupancy |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module cell_fifo
  import cell_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  cell_t                  wdata_i,
  output cell_t                  rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  cell_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             push;
  logic             pop;

  assign full_o      = (occ_q == OCC_W'(DEPTH));
  assign empty_o     = (occ_q == '0);
  assign occupancy_o = occ_q;
  assign rdata_o     = mem_q[rd_ptr_q];

  // Guard here too so a misbehaving caller can never over/underflow the count
  assign push = push_i && !full_o;
  assign pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cell_tx_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cell_tx_queue : cell FIFO feeding a serializer with minimum spacing   |
// | Optional drop counter: define CELL_TXQ_DROP_CNT_EN. Rev 1.0           |
// +-----------------------------------------------------------------------+
module cell_tx_queue
  import cell_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SPACING = 8
) (
  input  logic            clk,
  input  logic            rst,
  cell_tx_queue_if.slave  bus
);

  localparam int              CNT_W      = $clog2(SPACING);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SPACING - 1);

  txq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_out_q, valid_out_d;
  cell_t                  cell_out_q, cell_out_d;
  logic                   overflow_q;

  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   drop;
  cell_t                  head;
  logic [$clog2(DEPTH):0] occ;

  assign push = bus.valid_in && !full;
  assign drop = bus.valid_in && full;

  cell_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     (bus.cell_in),
    .rdata_o     (head),
    .full_o      (full),
    .empty_o     (empty),
    .occupancy_o (occ)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_out_d = 1'b0;
    cell_out_d  = cell_out_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && bus.tx_en) begin
          valid_out_d = 1'b1;
          cell_out_d  = head;
          pop         = 1'b1;
          cnt_d       = CNT_RELOAD;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // tx_en is ignored here so pulses stay exactly SPACING apart
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      valid_out_q <= 1'b0;
      cell_out_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_out_q <= valid_out_d;
      cell_out_q  <= cell_out_d;
      overflow_q  <= drop;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.cell_out  = cell_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.occupancy = occ;
  assign bus.overflow  = overflow_q;

`ifdef CELL_TXQ_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`endif

endmodule
`default_nettype wire
